// File: rtl/timebase_pkg.sv
// Shared definitions for the sample timebase: state encoding and default sizing.
package timebase_pkg;

   localparam int CNT_W       = 19;
   localparam int DIV_DEFAULT = 500000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      BURST = 2'd2,
      DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/half_period_counter.sv
// Half-period counter: counts up to a limit, then wraps to zero and flags the wrap.
// Kept generic so the PWM prescaler can reuse it.
module half_period_counter
   import timebase_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   input  logic         en_i,
   input  logic [W-1:0] limit_i,
   output logic         wrap_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // ">=" rather than "==" so a limit lowered below the current count still wraps.
   assign wrap_o = en_i && !clear_i && (count_q >= limit_i);

   // Next count: clear has priority, then wrap, then increment while enabled.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (wrap_o) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/sample_timebase.sv
// Servo-loop sample clock generator: runtime-programmable divisor with a shadow
// register, free-run and burst modes, one-cycle tick on each rising sample edge.
module sample_timebase #(
   parameter int CNT_W       = timebase_pkg::CNT_W,
   parameter int DIV_DEFAULT = timebase_pkg::DIV_DEFAULT,
   parameter int BURST_W     = 8
) (
   input  logic               Clck_in,
   input  logic               reset_Clock,
   input  logic               enable,
   input  logic               mode,
   input  logic               start,
   input  logic [BURST_W-1:0] burst_len,
   input  logic [CNT_W-1:0]   div_in,
   input  logic               div_load,
   output logic               div_ack,
   output logic               Clock_out,
   output logic               tick,
   output logic               busy,
   output logic               done
);

   import timebase_pkg::*;

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   div_active_q, div_active_d;
   logic [CNT_W-1:0]   shadow_q, shadow_d;
   logic               pending_q, pending_d;
   logic [BURST_W-1:0] remaining_q, remaining_d;
   logic               clk_out_q, clk_out_d;
   logic               tick_q, tick_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               div_ack_q, div_ack_d;

   logic               running;
   logic               cnt_clear;
   logic               cnt_en;
   logic               wrap;
   logic               rise;

   assign running   = (state_q != IDLE);
   assign cnt_clear = !running || !enable;
   assign cnt_en    = running && enable;
   // A wrap while the output is low is the rising edge that the tick marks.
   assign rise      = wrap && !clk_out_q;

   half_period_counter #(
      .W (CNT_W)
   ) u_counter (
      .clk_i   (Clck_in),
      .rst_ni  (reset_Clock),
      .clear_i (cnt_clear),
      .en_i    (cnt_en),
      .limit_i (div_active_q),
      .wrap_o  (wrap)
   );

   // Shadow divisor: loads land in the shadow and move to the active divisor only at a
   // half-period boundary (or straight away when idle), so the output never glitches.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      shadow_d     = shadow_q;
      pending_d    = pending_q;
      div_active_d = div_active_q;
      div_ack_d    = div_load;
      if (pending_q && (wrap || (state_q == IDLE))) begin
         div_active_d = shadow_q;
         pending_d    = 1'b0;
      end
      // A load coinciding with a transfer overrides the clear: the new value waits for the next boundary.
      if (div_load) begin
         shadow_d  = div_in;
         pending_d = 1'b1;
      end
   end

   // Mode FSM plus output clock, tick and done generation.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
      tick_d      = rise;
      clk_out_d   = wrap ? !clk_out_q : clk_out_q;

      case (state_q)
         IDLE: begin
            clk_out_d = 1'b0;
            if (enable) begin
               if (!mode) begin
                  state_d = RUN;
               end else if (start) begin
                  if (burst_len == '0) begin
                     done_d = 1'b1;
                  end else begin
                     remaining_d = burst_len;
                     state_d     = BURST;
                  end
               end
            end
         end
         RUN: begin
            state_d = RUN;
         end
         BURST: begin
            if (rise) begin
               remaining_d = remaining_q - BURST_W'(1);
               if (remaining_q <= BURST_W'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Entered on a rising edge, so the next wrap is the falling edge that ends the burst.
            if (wrap) begin
               state_d   = IDLE;
               done_d    = 1'b1;
               clk_out_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Dropping enable aborts any activity silently; the pending divisor survives.
      if (running && !enable) begin
         state_d   = IDLE;
         clk_out_d = 1'b0;
         tick_d    = 1'b0;
         done_d    = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge Clck_in or negedge reset_Clock) begin
      if (!reset_Clock) begin
         state_q      <= IDLE;
         div_active_q <= DIV_RST;
         shadow_q     <= DIV_RST;
         pending_q    <= 1'b0;
         remaining_q  <= '0;
         clk_out_q    <= 1'b0;
         tick_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         div_ack_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_active_q <= div_active_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         remaining_q  <= remaining_d;
         clk_out_q    <= clk_out_d;
         tick_q       <= tick_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         div_ack_q    <= div_ack_d;
      end
   end

   assign Clock_out = clk_out_q;
   assign tick      = tick_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign div_ack   = div_ack_q;

endmodule

// File: tb/tb_sample_timebase.sv
// Directed bench for sample_timebase with DIV_DEFAULT=3 (half period 4 cycles, period 8).
// Each loop index i is the rising edge just taken; outputs are sampled 1 time unit later.
module tb_sample_timebase;

   localparam int CNT_W   = 19;
   localparam int BURST_W = 8;

   logic               Clck_in;
   logic               reset_Clock;
   logic               enable;
   logic               mode;
   logic               start;
   logic [BURST_W-1:0] burst_len;
   logic [CNT_W-1:0]   div_in;
   logic               div_load;
   logic               div_ack;
   logic               Clock_out;
   logic               tick;
   logic               busy;
   logic               done;

   int tests_run;
   int tests_failed;

   sample_timebase #(
      .CNT_W       (CNT_W),
      .DIV_DEFAULT (3),
      .BURST_W     (BURST_W)
   ) dut (
      .Clck_in     (Clck_in),
      .reset_Clock (reset_Clock),
      .enable      (enable),
      .mode        (mode),
      .start       (start),
      .burst_len   (burst_len),
      .div_in      (div_in),
      .div_load    (div_load),
      .div_ack     (div_ack),
      .Clock_out   (Clock_out),
      .tick        (tick),
      .busy        (busy),
      .done        (done)
   );

   initial Clck_in = 1'b0;
   always #5 Clck_in = ~Clck_in;

   task automatic step();
      @(posedge Clck_in);
      #1;
   endtask

   task automatic do_reset();
      reset_Clock = 1'b0;
      enable      = 1'b0;
      mode        = 1'b0;
      start       = 1'b0;
      burst_len   = '0;
      div_in      = '0;
      div_load    = 1'b0;
      repeat (2) step();
      reset_Clock = 1'b1;
   endtask

   task automatic test_reset();
      logic [4:0] outs;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         outs = {Clock_out, tick, busy, done, div_ack};
         tests_run++;
         if (outs !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_idle[%0d]: outputs {clk,tick,busy,done,ack} got %b expected 00000", i, outs);
         end
      end
   endtask

   task automatic test_free_run();
      logic [15:0] exp_clk;
      logic [15:0] exp_tick;
      exp_clk  = 16'hF0F0;
      exp_tick = 16'h1010;
      do_reset();
      enable = 1'b1;
      mode   = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step();
         tests_run++;
         if (Clock_out !== exp_clk[i]) begin
            tests_failed++;
            $display("FAIL free_run_clk[%0d]: got %b expected %b", i, Clock_out, exp_clk[i]);
         end
         tests_run++;
         if (tick !== exp_tick[i]) begin
            tests_failed++;
            $display("FAIL free_run_tick[%0d]: got %b expected %b", i, tick, exp_tick[i]);
         end
         tests_run++;
         if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL free_run_busy[%0d]: got %b expected 1", i, busy);
         end
      end
   endtask

   task automatic test_div_load();
      logic [15:0] exp_clk;
      logic [15:0] exp_tick;
      logic [15:0] exp_ack;
      exp_clk  = 16'hCCF0;
      exp_tick = 16'h4410;
      exp_ack  = 16'h0040;
      do_reset();
      enable = 1'b1;
      mode   = 1'b0;
      div_in = 19'd1;
      for (int i = 0; i < 16; i++) begin
         div_load = (i == 6);
         step();
         tests_run++;
         if (Clock_out !== exp_clk[i]) begin
            tests_failed++;
            $display("FAIL div_load_clk[%0d]: got %b expected %b", i, Clock_out, exp_clk[i]);
         end
         tests_run++;
         if (tick !== exp_tick[i]) begin
            tests_failed++;
            $display("FAIL div_load_tick[%0d]: got %b expected %b", i, tick, exp_tick[i]);
         end
         tests_run++;
         if (div_ack !== exp_ack[i]) begin
            tests_failed++;
            $display("FAIL div_load_ack[%0d]: got %b expected %b", i, div_ack, exp_ack[i]);
         end
      end
      div_load = 1'b0;
   endtask

   task automatic test_burst();
      logic [31:0] exp_clk;
      logic [31:0] exp_tick;
      logic [31:0] exp_done;
      logic [31:0] exp_busy;
      int          ticks;
      exp_clk  = 32'h00F0F0F0;
      exp_tick = 32'h00101010;
      exp_done = 32'h01000000;
      exp_busy = 32'h00FFFFFF;
      ticks    = 0;
      do_reset();
      enable    = 1'b1;
      mode      = 1'b1;
      burst_len = 8'd3;
      for (int i = 0; i < 32; i++) begin
         start = (i == 0);
         step();
         if (tick === 1'b1) ticks++;
         tests_run++;
         if (Clock_out !== exp_clk[i]) begin
            tests_failed++;
            $display("FAIL burst_clk[%0d]: got %b expected %b", i, Clock_out, exp_clk[i]);
         end
         tests_run++;
         if (tick !== exp_tick[i]) begin
            tests_failed++;
            $display("FAIL burst_tick[%0d]: got %b expected %b", i, tick, exp_tick[i]);
         end
         tests_run++;
         if (done !== exp_done[i]) begin
            tests_failed++;
            $display("FAIL burst_done[%0d]: got %b expected %b", i, done, exp_done[i]);
         end
         tests_run++;
         if (busy !== exp_busy[i]) begin
            tests_failed++;
            $display("FAIL burst_busy[%0d]: got %b expected %b", i, busy, exp_busy[i]);
         end
      end
      tests_run++;
      if (ticks != 3) begin
         tests_failed++;
         $display("FAIL burst_tick_count: got %0d expected 3", ticks);
      end
   endtask

   task automatic test_zero_burst();
      logic [7:0] exp_done;
      exp_done = 8'h01;
      do_reset();
      enable    = 1'b1;
      mode      = 1'b1;
      burst_len = 8'd0;
      for (int i = 0; i < 8; i++) begin
         start = (i == 0);
         step();
         tests_run++;
         if (done !== exp_done[i]) begin
            tests_failed++;
            $display("FAIL zero_burst_done[%0d]: got %b expected %b", i, done, exp_done[i]);
         end
         tests_run++;
         if ({busy, tick, Clock_out} !== 3'b000) begin
            tests_failed++;
            $display("FAIL zero_burst_idle[%0d]: {busy,tick,clk} got %b expected 000", i, {busy, tick, Clock_out});
         end
      end
   endtask

   task automatic test_enable_abort();
      logic [31:0] exp_clk;
      logic [31:0] exp_tick;
      logic [31:0] exp_busy;
      exp_clk  = 32'h0001E030;
      exp_tick = 32'h00002010;
      exp_busy = 32'h000FFE3F;
      do_reset();
      burst_len = 8'd5;
      for (int i = 0; i < 20; i++) begin
         enable = !(i >= 6 && i <= 8);
         mode   = (i < 9);
         start  = (i == 0);
         step();
         tests_run++;
         if (Clock_out !== exp_clk[i]) begin
            tests_failed++;
            $display("FAIL abort_clk[%0d]: got %b expected %b", i, Clock_out, exp_clk[i]);
         end
         tests_run++;
         if (tick !== exp_tick[i]) begin
            tests_failed++;
            $display("FAIL abort_tick[%0d]: got %b expected %b", i, tick, exp_tick[i]);
         end
         tests_run++;
         if (busy !== exp_busy[i]) begin
            tests_failed++;
            $display("FAIL abort_busy[%0d]: got %b expected %b", i, busy, exp_busy[i]);
         end
         tests_run++;
         if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_done[%0d]: got %b expected 0", i, done);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic [15:0] exp_clk;
      logic [15:0] exp_tick;
      logic [4:0]  outs;
      exp_clk  = 16'hF0F0;
      exp_tick = 16'h1010;
      do_reset();
      enable = 1'b1;
      mode   = 1'b0;
      div_in = 19'd1;
      for (int i = 0; i < 7; i++) begin
         div_load = (i == 6);
         step();
      end
      div_load = 1'b0;
      tests_run++;
      if ({Clock_out, div_ack} !== 2'b11) begin
         tests_failed++;
         $display("FAIL rst_mid_pre: {clk,ack} got %b expected 11", {Clock_out, div_ack});
      end
      reset_Clock = 1'b0;
      #2;
      outs = {Clock_out, tick, busy, done, div_ack};
      tests_run++;
      if (outs !== 5'b0) begin
         tests_failed++;
         $display("FAIL rst_mid_async: outputs got %b expected 00000", outs);
      end
      step();
      reset_Clock = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         tests_run++;
         if (Clock_out !== exp_clk[i]) begin
            tests_failed++;
            $display("FAIL rst_mid_clk[%0d]: got %b expected %b", i, Clock_out, exp_clk[i]);
         end
         tests_run++;
         if (tick !== exp_tick[i]) begin
            tests_failed++;
            $display("FAIL rst_mid_tick[%0d]: got %b expected %b", i, tick, exp_tick[i]);
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_free_run();
      test_div_load();
      test_burst();
      test_zero_burst();
      test_enable_abort();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
